// File: rtl/ifetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch side drives req/addr; memory answers with ready/rdata.
interface ifetch_if #(
  parameter int unsigned INSWIDTH = 32,
  parameter int unsigned AWIDTH   = 32
) ();
  logic                imem_req;
  logic [AWIDTH-1:0]   imem_addr;
  logic                imem_ready;
  logic [INSWIDTH-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// presents {instruction, PC+4} to IF/ID, honouring stall and branch redirects.
module ifetch_unit #(
  parameter int unsigned       INSWIDTH = 32,
  parameter int unsigned       AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect,
  input  logic [AWIDTH-1:0]   redirect_pc,
  ifetch_if.master            imem,
  output logic [INSWIDTH-1:0] ins_o,
  output logic [AWIDTH-1:0]   pcnext_o,
  output logic                valid_o
);

  typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   pc_q, pc_d;
  logic [AWIDTH-1:0]   redir_pc_q, redir_pc_d;
  logic [INSWIDTH-1:0] hold_ins_q, hold_ins_d;

  logic [AWIDTH-1:0]   target;
  logic [AWIDTH-1:0]   pc_plus4;

  assign target   = redirect_pc & ~AWIDTH'(3);
  assign pc_plus4 = pc_q + AWIDTH'(4);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    hold_ins_d = hold_ins_q;
    case (state_q)
      FETCH: begin
        if (imem.imem_ready) begin
          if (redirect)   pc_d = target;
          else if (stall) begin
            hold_ins_d = imem.imem_rdata;
            state_d    = HOLD;
          end
          else            pc_d = pc_plus4;
        end else if (redirect) begin
          redir_pc_d = target;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        // A redirect coinciding with ready must beat the previously latched target.
        if (redirect) redir_pc_d = target;
        if (imem.imem_ready) begin
          pc_d    = redirect ? target : redir_pc_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      redir_pc_q <= '0;
      hold_ins_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      hold_ins_q <= hold_ins_d;
    end
  end

  // rst_n gates req/valid so nothing is issued or presented while reset is held.
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;
    valid_o        = 1'b0;
    case (state_q)
      FETCH: begin
        imem.imem_req = rst_n;
        valid_o       = rst_n & imem.imem_ready & ~redirect;
      end
      DRAIN:   imem.imem_req = rst_n;
      HOLD:    valid_o = rst_n & ~redirect;
      default: valid_o = 1'b0;
    endcase
    ins_o    = valid_o ? ((state_q == HOLD) ? hold_ins_q : imem.imem_rdata) : '0;
    pcnext_o = pc_plus4;
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: a behavioural fetch model is compared every cycle,
// with directed scenarios pinning literal values.
module tb_ifetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ins_o;
  logic [31:0] pcnext_o;
  logic        valid_o;

  ifetch_if #(.INSWIDTH(32), .AWIDTH(32)) bus ();

  ifetch_unit #(.INSWIDTH(32), .AWIDTH(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .ins_o       (ins_o),
    .pcnext_o    (pcnext_o),
    .valid_o     (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h8C220004;
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]} ^ 32'h13579BDF;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: the PC, an optional held instruction, and an optional
  // wrong-path response still owed by memory together with where to go afterwards.
  logic [31:0] m_pc;
  bit          m_held;
  logic [31:0] m_held_ins;
  bit          m_discard;
  logic [31:0] m_dest;

  task automatic model_reset();
    m_pc = 32'h0; m_held = 0; m_held_ins = '0; m_discard = 0; m_dest = '0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    tgt = {redirect_pc[31:2], 2'b00};
    if (m_held) begin
      if (redirect)    begin m_pc = tgt;       m_held = 0; end
      else if (!stall) begin m_pc = m_pc + 4;  m_held = 0; end
    end else if (m_discard) begin
      if (redirect) m_dest = tgt;
      if (bus.imem_ready) begin m_pc = m_dest; m_discard = 0; end
    end else if (bus.imem_ready) begin
      if (redirect)   m_pc = tgt;
      else if (stall) begin m_held = 1; m_held_ins = mem_word(m_pc); end
      else            m_pc = m_pc + 4;
    end else if (redirect) begin
      m_discard = 1; m_dest = tgt;
    end
  endtask

  logic [31:0] s_addr, s_ins, s_pcn;
  logic        s_req, s_valid;

  task automatic compare_outputs();
    bit          e_req, e_valid;
    logic [31:0] e_ins;
    e_req   = !m_held;
    e_valid = m_held ? !redirect : (!m_discard && bus.imem_ready && !redirect);
    e_ins   = e_valid ? (m_held ? m_held_ins : mem_word(m_pc)) : 32'h0;
    s_req = bus.imem_req; s_addr = bus.imem_addr; s_valid = valid_o;
    s_ins = ins_o;        s_pcn  = pcnext_o;
    chk("imem_req", {31'b0, s_req}, {31'b0, e_req});
    if (e_req) chk("imem_addr", s_addr, m_pc);
    chk("valid_o", {31'b0, s_valid}, {31'b0, e_valid});
    chk("ins_o", s_ins, e_ins);
    chk("pcnext_o", s_pcn, m_pc + 32'd4);
  endtask

  // Entered and left at posedge+1: drive, compare mid-cycle, advance model at the edge.
  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
    stall = st; redirect = rd; redirect_pc = rpc; bus.imem_ready = rdy;
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 0; redirect = 0; bus.imem_ready = 0;
    #1;
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_ins", ins_o, 32'h0);
    chk("rst_pcnext", pcnext_o, 32'h4);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; redirect = 0; redirect_pc = '0; bus.imem_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Zero-wait streaming from reset.
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1);
      chk("t1_addr", s_addr, 32'(i * 4));
      chk("t1_pcnext", s_pcn, 32'(i * 4 + 4));
      chk("t1_valid", {31'b0, s_valid}, 32'h1);
    end

    // Wait states at address 8.
    cycle(0, 1, 32'h8, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      chk("t2_addr_hold", s_addr, 32'h8);
      chk("t2_valid", {31'b0, s_valid}, 32'h0);
      chk("t2_ins", s_ins, 32'h0);
    end
    cycle(0, 0, 0, 1);
    chk("t2_valid_ready", {31'b0, s_valid}, 32'h1);
    cycle(0, 0, 0, 1);
    chk("t2_next_addr", s_addr, 32'hC);

    // Stall holding the instruction fetched at 4.
    cycle(0, 1, 32'h4, 1);
    cycle(1, 0, 0, 1);
    chk("t3_ins", s_ins, 32'h8C220004);
    cycle(1, 0, 0, 1);
    chk("t3_hold_req", {31'b0, s_req}, 32'h0);
    chk("t3_hold_ins", s_ins, 32'h8C220004);
    chk("t3_hold_pcnext", s_pcn, 32'h8);
    cycle(0, 0, 0, 1);
    chk("t3_release_ins", s_ins, 32'h8C220004);
    cycle(0, 0, 0, 1);
    chk("t3_next_addr", s_addr, 32'h8);

    // Redirect with zero-wait memory costs one bubble.
    cycle(0, 1, 32'h40, 1);
    chk("t4_bubble", {31'b0, s_valid}, 32'h0);
    cycle(0, 0, 0, 1);
    chk("t4_target", s_addr, 32'h40);

    // Redirect while waiting, re-redirect during drain.
    cycle(0, 1, 32'h8, 1);
    cycle(0, 1, 32'h40, 0);
    cycle(0, 1, 32'h80, 0);
    chk("t5_addr_held", s_addr, 32'h8);
    cycle(0, 0, 0, 1);
    chk("t5_discard", {31'b0, s_valid}, 32'h0);
    chk("t5_addr_drain", s_addr, 32'h8);
    cycle(0, 0, 0, 1);
    chk("t5_newest_target", s_addr, 32'h80);

    // Asynchronous reset mid-handshake, then the PC wrap.
    cycle(0, 0, 0, 0);
    do_reset();
    cycle(0, 1, 32'hFFFFFFFF, 1);
    cycle(0, 0, 0, 1);
    chk("t6_wrap_addr", s_addr, 32'hFFFFFFFC);
    chk("t6_wrap_pcnext", s_pcn, 32'h0);
    cycle(0, 0, 0, 1);
    chk("t6_after_wrap", s_addr, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom,
            $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
